// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between instruction fetch and the load unit.
// Load has priority. Fetch wins after STARVE_MAX consecutive contested losses.
module mem_read_arbiter #(
  parameter int ADDR_W     = 61,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} stateT;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  stateT             stateReg, stateNext;
  logic [3:0]        latCntReg, latCntNext;
  logic [3:0]        starveCntReg, starveCntNext;
  logic              ownerReg, ownerNext;  // 1 = load, 0 = fetch
  logic [ADDR_W-1:0] memAddrReg, memAddrNext;
  logic [DATA_W-1:0] ifRdataReg, ifRdataNext;
  logic [DATA_W-1:0] ldRdataReg, ldRdataNext;
  logic              inWindow, ifWin, ldWin;

  always_comb begin
    inWindow = (stateReg != ACCESS);
    ldWin    = inWindow && ld_req && !(if_req && (starveCntReg == STARVE_TOP));
    ifWin    = inWindow && if_req && !ldWin;
  end

  // Grants are combinational, so they must be masked explicitly during reset.
  assign if_gnt    = rst_n & ifWin;
  assign ld_gnt    = rst_n & ldWin;
  assign if_rvalid = (stateReg == RESP) && !ownerReg;
  assign ld_rvalid = (stateReg == RESP) && ownerReg;
  assign busy      = (stateReg == ACCESS);
  assign mem_addr  = memAddrReg;
  assign if_rdata  = ifRdataReg;
  assign ld_rdata  = ldRdataReg;

  always_comb begin
    stateNext     = stateReg;
    latCntNext    = latCntReg;
    starveCntNext = starveCntReg;
    ownerNext     = ownerReg;
    memAddrNext   = memAddrReg;
    ifRdataNext   = ifRdataReg;
    ldRdataNext   = ldRdataReg;
    case (stateReg)
      ACCESS: begin
        if (latCntReg == LAT_LAST) begin
          stateNext = RESP;
          if (ownerReg) ldRdataNext = mem_rdata;
          else          ifRdataNext = mem_rdata;
        end else begin
          latCntNext = latCntReg + 4'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        if (ifWin || ldWin) begin
          stateNext   = ACCESS;
          latCntNext  = 4'd1;
          ownerNext   = ldWin;
          memAddrNext = ldWin ? ld_addr : if_addr;
        end
        // Any window cycle where fetch is not left waiting on a load resets starvation.
        if (ifWin || !if_req) begin
          starveCntNext = 4'd0;
        end else if (starveCntReg != STARVE_TOP) begin
          starveCntNext = starveCntReg + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      latCntReg    <= 4'd0;
      starveCntReg <= 4'd0;
      ownerReg     <= 1'b0;
      memAddrReg   <= '0;
      ifRdataReg   <= '0;
      ldRdataReg   <= '0;
    end else begin
      stateReg     <= stateNext;
      latCntReg    <= latCntNext;
      starveCntReg <= starveCntNext;
      ownerReg     <= ownerNext;
      memAddrReg   <= memAddrNext;
      ifRdataReg   <= ifRdataNext;
      ldRdataReg   <= ldRdataNext;
    end
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares a single memory read port between the instruction-fetch requester and the load unit of the core. It arbitrates with load priority plus fetch anti-starvation, and holds the granted address stable for a fixed memory latency. It then returns the read doubleword to the winning requester with a one-cycle valid pulse. The block sits between the core's fetch/load logic and one read port of `mem`, so a single-ported memory can serve both streams.

## Interface
- `ADDR_W`, 61, doubleword address width (matches the `mem` read port).
- `DATA_W`, 64, read data width.
- `MEM_LAT`, 2, cycles the address must be held before `mem_rdata` is valid; legal range 1..15.
- `STARVE_MAX`, 4, consecutive lost contested arbitrations after which fetch wins; legal range 1..15.

- `clk` in 1: sole clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request. Held high with `if_addr` stable until `if_gnt`.
- `if_addr` in ADDR_W: fetch doubleword address.
- `if_gnt` out 1: combinational. Fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse. `if_rdata` is valid.
- `if_rdata` out DATA_W: registered fetch data. Held until the next fetch response.
- `ld_req`, `ld_addr`, `ld_gnt`, `ld_rvalid`, `ld_rdata`: same as the fetch set, for the load unit.
- `mem_addr` out ADDR_W: registered address to the memory read port.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high when the state is ACCESS.

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: counter `lat_cnt` counts 1..MEM_LAT.
  - RESP: one cycle; the winner's `rvalid` is high.
- Grant window: state IDLE or RESP. Outside the window both `gnt` outputs are 0, and requests wait.
- Arbitration inside the window:
  - Only one requester high: that requester is granted.
  - Both high: load is granted, unless `starve_cnt == STARVE_MAX`, in which case fetch is granted.
  - At most one `gnt` is high per cycle.
- `starve_cnt` update, in window cycles only:
  - Both requests high and load granted: increment, saturating at STARVE_MAX.
  - Fetch granted, or `if_req` low: clear to 0.
- On grant:
  - The winner's address is latched into `mem_addr`.
  - The winner's identity is latched into `owner`.
  - Next state is ACCESS with `lat_cnt = 1`.
- ACCESS:
  - `lat_cnt < MEM_LAT`: increment `lat_cnt`.
  - `lat_cnt == MEM_LAT`: capture `mem_rdata` into `owner`'s rdata register; next state is RESP.
- RESP:
  - `owner`'s `rvalid` is 1.
  - If a grant occurs this cycle, next state is ACCESS; otherwise IDLE.
- `mem_addr` holds its last value outside ACCESS. It changes only on a grant.
- The rdata register of the non-owner is never written.
- Reset (asynchronous, any state, including mid-access):
  - State IDLE, `lat_cnt` 0, `starve_cnt` 0, `owner` fetch.
  - `mem_addr` 0, both rdata registers 0.
  - All `gnt`/`rvalid` outputs 0, `busy` 0.
  - An in-flight access is dropped and produces no `rvalid`.
- `gnt` is forced 0 while `rst_n` is low.

## Timing
- Grant in cycle t (combinational from `req` and state). The latch happens on the edge ending cycle t.
- `mem_addr` is valid in cycles t+1 .. t+MEM_LAT. `busy` is high in the same cycles.
- `mem_rdata` is sampled on the edge ending cycle t+MEM_LAT.
- `rvalid` is high in cycle t+MEM_LAT+1, so load-to-use latency is MEM_LAT+1 cycles.
- Back-to-back: the next grant can occur in the RESP cycle. Peak throughput is one access per MEM_LAT+1 cycles.
- A requester that keeps `req` high after `gnt` is treated as a new request at the next grant window.
- `req` and `gnt` in the same window cycle complete the handshake. The requester may change its address from the following cycle.

## Test plan
- Reset:
  - Stimulus: drive `rst_n`=0 mid-ACCESS with MEM_LAT=2.
  - Required: all outputs 0 immediately, before any clock edge. No `rvalid` follows. After release, state is IDLE and the first request is granted in its first cycle.
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x10 in cycle 0; memory returns 0xDEADBEEF00000001.
  - Required: `if_gnt`=1 in cycle 0. `mem_addr`=0x10 in cycles 1-2. `if_rvalid`=1 with that data in cycle 3.
- Contention:
  - Stimulus: both requests held high continuously, STARVE_MAX=4.
  - Required: grant order is ld, ld, ld, ld, if, ld, ld, ld, ld, if.
  - Required: grants spaced 3 cycles apart. `ld_rdata` is never overwritten by fetch data.
- Back-to-back:
  - Stimulus: `ld_req` high for two transactions.
  - Required: the second `ld_gnt` coincides with the first `ld_rvalid`.
  - Required: `busy` gap is exactly 1 cycle, and `mem_addr` switches at that edge.
- Latency sweep:
  - Stimulus: MEM_LAT=1 and MEM_LAT=15.
  - Required: `rvalid` at grant+2 and grant+16 respectively. `mem_addr` stable for the entire ACCESS window.
